// File: rtl/imem_load_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_pkg
// Brief   : Shared types and constants for the instruction-memory loader.
// Revision: 1.0 - initial release
// ============================================================================
package imem_load_pkg;

    // Controller states: pass-through, byte gathering, single write, done pulse
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } load_state_t;

    // Returned to the core while it is held; equals the memory fill value
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000003;

    localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_ctrl_if
// Brief   : Loader stream, core fetch and memory port signals of the
//           instruction-memory load controller.
// Revision: 1.0 - initial release
// ============================================================================
interface imem_load_ctrl_if;

    logic        load_start;
    logic [15:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        core_hold;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        load_done;
    logic        load_err;

    // Environment side: loader, core and memory
    modport master (
        output load_start, load_len, byte_valid, byte_data, fetch_addr, mem_rdata,
        input  byte_ready, fetch_instr, core_hold, mem_addr, mem_we, mem_wdata,
               load_done, load_err
    );

    // Controller side
    modport slave (
        input  load_start, load_len, byte_valid, byte_data, fetch_addr, mem_rdata,
        output byte_ready, fetch_instr, core_hold, mem_addr, mem_we, mem_wdata,
               load_done, load_err
    );

endinterface
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : imem_word_packer
// Brief   : Gathers bytes into a little-endian 32-bit word; the first byte
//           lands in bits [7:0].
// Revision: 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_buf;

    // Insert each accepted byte at its lane; the counter wraps to 0 after the 4th
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_byte_cnt <= '0;
            r_buf      <= '0;
        end else if (accept) begin
            r_buf[{r_byte_cnt, 3'b000} +: 8] <= byte_data;
            r_byte_cnt                       <= r_byte_cnt + 2'd1;
        end
    end

    // High while the next accepted byte completes the word
    assign word_full = (r_byte_cnt == LAST_BYTE);
    assign word      = r_buf;

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_ctrl
// Brief   : Shares the instruction-memory address port between core fetch and
//           a byte-stream program loader; holds the core during a load.
// Revision: 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int          MEM_SIZE  = 256,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    imem_load_ctrl_if.slave bus
);

    // One extra bit so that a word index equal to MEM_SIZE is representable
    localparam int          IDX_W   = $clog2(MEM_SIZE) + 1;
    localparam logic [16:0] MAX_LEN = 17'(MEM_SIZE);

    load_state_t      r_state;
    load_state_t      w_next_state;
    logic [IDX_W-1:0] r_word_idx;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] w_idx_next;
    logic             r_load_done;
    logic             r_load_err;

    logic             w_len_valid;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_accept;
    logic             w_word_full;
    logic [31:0]      w_word;

    logic             w_core_hold;
    logic             w_byte_ready;
    logic             w_mem_we;
    logic [31:0]      w_mem_addr;
    logic [31:0]      w_fetch_instr;

    assign w_len_valid = (bus.load_len != 16'd0) && ({1'b0, bus.load_len} <= MAX_LEN);
    assign w_start_ok  = (r_state == IDLE) && bus.load_start && w_len_valid;
    assign w_start_bad = (r_state == IDLE) && bus.load_start && !w_len_valid;
    assign w_accept    = (r_state == ASSEMBLE) && bus.byte_valid;
    assign w_idx_next  = r_word_idx + 1'b1;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start_ok),
        .accept    (w_accept),
        .byte_data (bus.byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and port muxing; in IDLE the core owns the memory port
    always_comb begin
        w_next_state  = r_state;
        w_core_hold   = (r_state != IDLE);
        w_byte_ready  = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = bus.fetch_addr;
        w_fetch_instr = bus.mem_rdata;
        if (r_state != IDLE) begin
            w_mem_addr    = {{(30 - IDX_W){1'b0}}, r_word_idx, 2'b00};
            w_fetch_instr = NOP_INSTR;
        end
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) w_next_state = ASSEMBLE;
            end
            ASSEMBLE: begin
                w_byte_ready = 1'b1;
                if (w_accept && w_word_full) w_next_state = WRITE;
            end
            WRITE: begin
                // A reset landing on this cycle must not commit the word
                w_mem_we     = !rst;
                w_next_state = (w_idx_next == r_len) ? DONE : ASSEMBLE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Word index, latched length and the registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_idx  <= '0;
            r_len       <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= (r_state == WRITE) && (w_idx_next == r_len);
            r_load_err  <= w_start_bad;
            if (w_start_ok) begin
                r_len      <= bus.load_len[IDX_W-1:0];
                r_word_idx <= '0;
            end else if (r_state == WRITE) begin
                r_word_idx <= w_idx_next;
            end
        end
    end

    assign bus.core_hold   = w_core_hold;
    assign bus.byte_ready  = w_byte_ready;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_word;
    assign bus.fetch_instr = w_fetch_instr;
    assign bus.load_done   = r_load_done;
    assign bus.load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_load_ctrl
// Brief   : Scoreboard bench for imem_load_ctrl with a word-level load model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    localparam int          MEM_SIZE = 256;
    localparam logic [31:0] NOP      = 32'h00000003;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    imem_load_ctrl_if bus();

    imem_load_ctrl #(
        .MEM_SIZE  (MEM_SIZE),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural instruction memory with asynchronous read
    logic [31:0] tb_mem  [MEM_SIZE];
    logic [31:0] ref_mem [MEM_SIZE];

    assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_SIZE; i++) tb_mem[i] <= NOP;
            tb_mem[2] <= 32'h00500093;
        end else if (bus.mem_we) begin
            tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    // Scoreboard state
    wr_t         wr_q   [$];
    int          done_q [$];
    int          err_q  [$];
    logic [31:0] prog   [$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_en      = 1'b0;
    bit          prev_we     = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a pulse
    always @(negedge clk) begin
        wr_t e;
        int  tok;
        if (mon_en) begin
            if (bus.mem_we !== 1'b0) begin
                if (wr_q.size() == 0) begin
                    check32("unexpected_write_addr", bus.mem_addr, 32'hFFFFFFFF);
                end else begin
                    e = wr_q.pop_front();
                    check32("write_addr", bus.mem_addr, e.addr);
                    check32("write_data", bus.mem_wdata, e.data);
                end
            end
            if (bus.load_done !== 1'b0) begin
                if (done_q.size() == 0) check1("unexpected_done", bus.load_done, 1'b0);
                else begin
                    tok = done_q.pop_front();
                    check1("done_after_write", prev_we, 1'b1);
                end
            end
            if (bus.load_err !== 1'b0) begin
                if (err_q.size() == 0) check1("unexpected_err", bus.load_err, 1'b0);
                else tok = err_q.pop_front();
            end
            if (bus.core_hold === 1'b1) begin
                check32("held_instr", bus.fetch_instr, NOP);
            end else begin
                check32("pass_addr", bus.mem_addr, bus.fetch_addr);
                check32("pass_instr", bus.fetch_instr, bus.mem_rdata);
            end
            prev_we = (bus.mem_we === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rejected start: one error pulse, no hold, no write
    task automatic reject(input int len);
        err_q.push_back(len);
        bus.load_start = 1'b1;
        bus.load_len   = 16'(len);
        tick();
        bus.load_start = 1'b0;
        check1("reject_no_hold", bus.core_hold, 1'b0);
        check1("reject_err_pulse", bus.load_err, 1'b1);
        tick();
        check1("reject_err_one_cycle", bus.load_err, 1'b0);
        check1("reject_still_idle", bus.core_hold, 1'b0);
    endtask

    // Load of prog[0..len-1]; abort_bytes>0 resets after that many bytes;
    // gap_at inserts three idle cycles before that byte index
    task automatic run_load(input int len, input int gap_pct, input int start_pct,
                            input int abort_bytes, input int gap_at);
        int          nbytes;
        int          nwords;
        int          t;
        logic [31:0] w;
        nwords = (abort_bytes > 0) ? abort_bytes / 4 : len;
        nbytes = (abort_bytes > 0) ? abort_bytes : 4 * len;
        for (int i = 0; i < nwords; i++) begin
            wr_q.push_back('{addr: 32'(i * 4), data: prog[i]});
            ref_mem[i] = prog[i];
        end
        if (abort_bytes == 0) done_q.push_back(len);

        bus.load_start = 1'b1;
        bus.load_len   = 16'(len);
        tick();
        bus.load_start = 1'b0;
        check1("hold_after_start", bus.core_hold, 1'b1);

        for (int k = 0; k < nbytes; k++) begin
            if (k == gap_at) begin
                bus.byte_valid = 1'b0;
                repeat (3) tick();
            end
            while ($urandom_range(99) < gap_pct) begin
                bus.byte_valid = 1'b0;
                bus.fetch_addr = {22'd0, 8'($urandom_range(255)), 2'b00};
                if ($urandom_range(99) < start_pct) begin
                    bus.load_start = 1'b1;
                    bus.load_len   = 16'($urandom_range(0, 300));
                end
                tick();
                bus.load_start = 1'b0;
            end
            w = prog[k / 4];
            bus.byte_valid = 1'b1;
            bus.byte_data  = w[8 * (k % 4) +: 8];
            t = 0;
            while (bus.byte_ready !== 1'b1) begin
                tick();
                t++;
                if (t > 20) begin
                    check1("byte_ready_timeout", bus.byte_ready, 1'b1);
                    bus.byte_valid = 1'b0;
                    return;
                end
            end
            tick();
        end
        bus.byte_valid = 1'b0;

        if (abort_bytes > 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check1("reset_hold_low", bus.core_hold, 1'b0);
            check1("reset_ready_low", bus.byte_ready, 1'b0);
            check1("reset_no_write", bus.mem_we, 1'b0);
        end else begin
            check1("hold_in_write", bus.core_hold, 1'b1);
            tick();
            check1("hold_in_done", bus.core_hold, 1'b1);
            check1("done_pulse", bus.load_done, 1'b1);
            tick();
            check1("hold_released", bus.core_hold, 1'b0);
            check1("done_one_cycle", bus.load_done, 1'b0);
        end
    endtask

    task automatic random_prog(input int len);
        prog.delete();
        for (int i = 0; i < len; i++) prog.push_back($urandom);
    endtask

    initial begin
        int len;
        int sel;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = NOP;
        ref_mem[2] = 32'h00500093;

        rst            = 1'b1;
        mem_init       = 1'b1;
        bus.load_start = 1'b0;
        bus.load_len   = 16'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        bus.fetch_addr = 32'd0;
        repeat (3) tick();
        rst      = 1'b0;
        mem_init = 1'b0;
        tick();
        mon_en = 1'b1;

        // Reset state
        check1("rst_core_hold", bus.core_hold, 1'b0);
        check1("rst_byte_ready", bus.byte_ready, 1'b0);
        check1("rst_mem_we", bus.mem_we, 1'b0);
        check1("rst_load_done", bus.load_done, 1'b0);
        check1("rst_load_err", bus.load_err, 1'b0);

        // Normal fetch pass-through
        bus.fetch_addr = 32'h8;
        #1;
        check32("fetch_mem_addr", bus.mem_addr, 32'h8);
        check32("fetch_instr", bus.fetch_instr, 32'h00500093);
        tick();

        // Two-word load, continuous stream
        prog = '{32'h12345678, 32'hDEADBEEF};
        run_load(2, 0, 0, 0, -1);

        // Same load with a 3-cycle gap before the third byte
        run_load(2, 0, 0, 0, 2);

        // Rejected lengths
        reject(0);
        reject(MEM_SIZE + 1);
        reject($urandom_range(MEM_SIZE + 2, 65535));

        // Reset after two bytes, then a one-word load
        random_prog(1);
        run_load(1, 0, 0, 2, -1);
        prog = '{32'h00000003};
        run_load(1, 0, 0, 0, -1);

        // Starts pulsed during ASSEMBLE must be ignored
        random_prog(3);
        run_load(3, 50, 70, 0, -1);

        // Randomized mix of loads, rejects and aborts
        for (int it = 0; it < 14; it++) begin
            sel = $urandom_range(99);
            len = $urandom_range(1, 8);
            random_prog(len);
            if (sel < 20) begin
                reject((sel < 10) ? 0 : $urandom_range(MEM_SIZE + 1, 65535));
            end else if (sel < 35) begin
                run_load(len, 20, 20, 4 * $urandom_range(0, len - 1) + $urandom_range(1, 3), -1);
            end else begin
                run_load(len, $urandom_range(0, 40), $urandom_range(0, 30), 0, -1);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        // Full-size load at the length boundary
        random_prog(MEM_SIZE);
        run_load(MEM_SIZE, 0, 0, 0, -1);
        tick();

        check32("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check32("done_outstanding", 32'(done_q.size()), 32'd0);
        check32("err_outstanding", 32'(err_q.size()), 32'd0);

        // Core sees the loaded program after release
        for (int a = 0; a < MEM_SIZE; a += 17) begin
            bus.fetch_addr = 32'(a * 4);
            #1;
            check32("fetch_loaded", bus.fetch_instr, ref_mem[a]);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller in front of the instruction memory that shares its single address port between core instruction fetch and a byte-stream program loader. In normal operation the core's PC passes straight through and reads asynchronously. On a load request the block holds the core, assembles incoming bytes into little-endian 32-bit words and writes them sequentially from address 0. It then releases the core.

Parameters:
MEM_SIZE, 256, number of 32-bit instruction words in the memory; maximum legal load length.
NOP_INSTR, 32'h00000003, word returned to the core while it is held; matches the memory fill value.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
load_start  input  1  one-cycle pulse requesting a program load; sampled only in IDLE.
load_len  input  16  number of words to load; sampled with load_start.
byte_valid  input  1  loader byte-stream valid.
byte_data  input  8  loader byte; first byte of each word maps to bits [7:0].
byte_ready  output  1  block can accept a byte this cycle.
fetch_addr  input  32  core PC (byte address).
fetch_instr  output  32  instruction returned to the core.
core_hold  output  1  core must stall and not retire while high.
mem_addr  output  32  byte address to the instruction memory.
mem_we  output  1  memory write enable, written at the clk edge.
mem_wdata  output  32  memory write data.
mem_rdata  input  32  asynchronous memory read data.
load_done  output  1  one-cycle pulse when the last word has been written.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- States: IDLE, ASSEMBLE, WRITE, DONE, encoded as an enum.
- Reset values:
  - State is IDLE, byte_cnt=0, word_idx=0, word buffer=0.
  - Registered outputs load_done=0 and load_err=0.
  - Combinational outputs follow from IDLE: core_hold=0, byte_ready=0, mem_we=0.
- IDLE:
  - mem_addr=fetch_addr, fetch_instr=mem_rdata, both combinational with zero latency.
  - mem_we=0, byte_ready=0.
- Load acceptance from IDLE:
  - If load_start and 1<=load_len<=MEM_SIZE: latch load_len, clear word_idx and byte_cnt, go to ASSEMBLE.
  - If load_start with load_len==0 or load_len>MEM_SIZE: pulse load_err for one cycle, stay in IDLE, no writes.
- core_hold = (state != IDLE). In any non-IDLE state fetch_instr=NOP_INSTR and mem_addr is driven by the loader.
- ASSEMBLE:
  - byte_ready=1. A byte is accepted on a clk edge where byte_valid && byte_ready.
  - The byte is placed at buffer[8*byte_cnt +: 8], and byte_cnt increments (2-bit).
  - Acceptance of the 4th byte (byte_cnt==3) moves to WRITE. Cycles without byte_valid leave all state unchanged.
- WRITE, exactly one cycle:
  - byte_ready=0, mem_we=1, mem_addr={word_idx,2'b00}, mem_wdata=buffer.
  - word_idx increments. If the new word_idx==latched len, go to DONE; else go to ASSEMBLE with byte_cnt=0.
- DONE, one cycle: load_done=1, core_hold still 1; then IDLE, where the core resumes from its current PC.
- load_start outside IDLE is ignored, with no error pulse.
- rst in any state aborts immediately: partial word discarded, no write in the reset cycle, core_hold=0 from the next cycle.
- word_idx is $clog2(MEM_SIZE)+1 bits wide so that word_idx==MEM_SIZE is representable; no wrap-around is possible because the length is checked at start.
- Throughput: 5 cycles per word with continuous byte_valid.

Decomposition:
- Package imem_load_pkg holds:
  - the state enum typedef (IDLE, ASSEMBLE, WRITE, DONE);
  - the NOP_INSTR default constant;
  - a BYTES_PER_WORD=4 constant.
- One sub-module is natural: imem_word_packer, holding byte_cnt and the 32-bit shift/insert buffer, with an accept input, a word_full output and a clear input.
- FSM and port muxing stay in imem_load_ctrl.

Test Plan:
- Normal fetch:
  - Stimulus: IDLE, fetch_addr=0x8, mem_rdata=0x00500093.
  - Required: mem_addr=0x8 and fetch_instr=0x00500093 in the same cycle; core_hold=0, mem_we=0.
- Two-word load:
  - Stimulus: load_start, load_len=2, continuous bytes 78 56 34 12 EF BE AD DE.
  - Required writes: 0x12345678 at mem_addr 0x0, then 0xDEADBEEF at mem_addr 0x4.
  - Required timing: load_done pulses one cycle after the second write; core_hold is high from the cycle after load_start through DONE; fetch_instr=0x00000003 while held.
- Gapped stream:
  - Stimulus: same load with byte_valid low for 3 cycles between bytes 2 and 3.
  - Required: identical write values and addresses, exactly two mem_we cycles.
- Rejected lengths:
  - Stimulus: load_len=0, then load_len=257 with MEM_SIZE=256.
  - Required: load_err one-cycle pulse each time, core_hold stays 0, no mem_we.
- Reset mid-load:
  - Stimulus: rst after 2 bytes are accepted.
  - Required: next cycle in IDLE, core_hold=0, byte_ready=0, no write.
  - Follow-up: a new load with len=1 and bytes 03 00 00 00 writes 0x00000003 at address 0x0.
- Ignored start:
  - Stimulus: load_start pulsed again during ASSEMBLE.
  - Required: no restart, no load_err; the original load completes with the correct word count.
